a2d_resp: RTL and testbench

A2D_RESP -- requirements
Module: a2d_resp

---
 rtl/a2d_pkg.sv | 22 ++
 rtl/sync_edge.sv | 33 +++
 rtl/a2d_resp.sv | 160 ++++++++++++++++
 tb/tb_a2d_resp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and FSM state encoding for the A2D response slave.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CHNL_W     = 3;
  localparam int RES_W      = 12;
  localparam int NUM_CHNL   = 8;

  // Wide enough to hold the count FRAME_BITS itself.
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // Position of the channel field inside a received command word.
  localparam int CHNL_LSB   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a third flop for one-clk rise/fall pulses.
// All flops preset high so an idle-high line shows no edge at reset release.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic ff1_q;
  logic ff2_q;
  logic ff3_q;

  // Synchronizer chain and previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
      ff3_q <= 1'b1;
    end else begin
      ff1_q <= async_i;
      ff2_q <= ff1_q;
      ff3_q <= ff2_q;
    end
  end

  assign sync_o = ff2_q;
  assign rise_o = ff2_q & ~ff3_q;
  assign fall_o = ~ff2_q & ff3_q;

endmodule

// File: rtl/a2d_resp.sv
// SPI slave returning a 12-bit result-table entry per 16-bit frame.
// The channel carried in one frame selects the entry returned in the next.
module a2d_resp
  import a2d_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr_en,
  input  logic [CHNL_W-1:0] wr_chnnl,
  input  logic [RES_W-1:0]  wr_data,
  output logic              frm_done,
  output logic [CHNL_W-1:0] last_chnnl
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;

  sync_edge u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(SS_n),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  sync_edge u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(SCLK),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  logic mosi_ff1_q;
  logic mosi_ff2_q;

  // MOSI needs only a level synchronizer; it is sampled on SCLK rise pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_ff1_q <= 1'b1;
      mosi_ff2_q <= 1'b1;
    end else begin
      mosi_ff1_q <= MOSI;
      mosi_ff2_q <= mosi_ff1_q;
    end
  end

  // The preset-high synchronizers produce a false SS_n fall if SS_n is
  // already low at reset release. Frames are only accepted once the preset
  // values have flushed and the bus has been seen idle (SS_n and SCLK high).
  logic [1:0] settle_q;
  logic       arm_q;

  // Settle counter and bus-idle arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 2'd0;
      arm_q    <= 1'b0;
    end else begin
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && ss_sync && sclk_sync) arm_q <= 1'b1;
    end
  end

  logic [RES_W-1:0] tbl_q [NUM_CHNL];

  // Result table write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHNL; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[wr_chnnl] <= wr_data;
    end
  end

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CHNL_W-1:0]     last_q, last_d;
  logic                  done_q, done_d;
  logic [RES_W-1:0]      load_val;

  // A write landing on the same cycle as the frame load is forwarded.
  assign load_val = (wr_en && (wr_chnnl == last_q)) ? wr_data : tbl_q[last_q];

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: frame start, bit shifting, completion and abort.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall && arm_q) begin
          tx_d    = {{(FRAME_BITS-RES_W){1'b0}}, load_val};
          cnt_d   = '0;
          state_d = LEAD;
        end
      end
      LEAD: begin
        // The first falling edge only opens the frame; MSB is already out.
        if (ss_rise)        state_d = IDLE;
        else if (sclk_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_d  = (rx_q << 1) | {{(FRAME_BITS-1){1'b0}}, mosi_ff2_q};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = DONE;
          end
          if (sclk_fall) tx_d = tx_q << 1;
        end
      end
      DONE: begin
        if (ss_rise) begin
          last_d  = rx_q[CHNL_LSB +: CHNL_W];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO       = ss_sync ? 1'b1 : tx_q[FRAME_BITS-1];
  assign frm_done   = done_q;
  assign last_chnnl = last_q;

endmodule

// File: tb/tb_a2d_resp.sv
// Directed bench for a2d_resp: SPI frames driven by a simple master model.
module tb_a2d_resp;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        wr_en;
  logic [2:0]  wr_chnnl;
  logic [11:0] wr_data;
  logic        frm_done;
  logic [2:0]  last_chnnl;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  a2d_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_en     (wr_en),
    .wr_chnnl  (wr_chnnl),
    .wr_data   (wr_data),
    .frm_done  (frm_done),
    .last_chnnl(last_chnnl)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count frm_done pulses, sampled away from the active edge.
  always @(negedge clk) if (frm_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tbl_write(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_chnnl = ch; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // wr_bit: -2 none, -1 write on the SS_n fall detect cycle, >=0 during that bit.
  task automatic spi_frame(input logic [15:0] mosi_w, input int nrise, input bit end_ss,
                           input int wr_bit, input logic [2:0] wch, input logic [11:0] wdat,
                           output logic [15:0] miso_w);
    miso_w = '0;
    @(negedge clk);
    SS_n = 1'b0;
    if (wr_bit == -1) begin
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_chnnl = wch; wr_data = wdat;
      @(negedge clk);
      wr_en = 1'b0;
    end
    repeat (6) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? mosi_w[15-i] : 1'b1;
      if (i == wr_bit) begin
        wr_en = 1'b1; wr_chnnl = wch; wr_data = wdat;
        @(negedge clk);
        wr_en = 1'b0;
      end
      repeat (6) @(negedge clk);
      if (i < 16) miso_w[15-i] = MISO;
      else chk("miso_after_bit16", {31'd0, MISO}, 32'd0);
      SCLK = 1'b1;
      repeat (6) @(negedge clk);
    end
    if (end_ss) begin
      SS_n = 1'b1;
      repeat (10) @(negedge clk);
    end
    $display("frame mosi=%h rises=%0d miso=%h last_chnnl=%0d", mosi_w, nrise, miso_w, last_chnnl);
  endtask

  function automatic logic [15:0] cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'd0};
  endfunction

  logic [15:0] mw;
  int          d0;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr_en = 1'b0; wr_chnnl = '0; wr_data = '0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {31'd0, MISO}, 32'd1);
    chk("rst_frm_done", {31'd0, frm_done}, 32'd0);
    chk("rst_last", {29'd0, last_chnnl}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Two frames addressing channel 5.
    tbl_write(3'd5, 12'hA5C);
    d0 = done_cnt;
    spi_frame(cmd(3'd5), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("f1_miso", {16'd0, mw}, 32'h0000);
    chk("f1_done", done_cnt - d0, 1);
    chk("f1_last", {29'd0, last_chnnl}, 32'd5);
    chk("idle_miso", {31'd0, MISO}, 32'd1);
    d0 = done_cnt;
    spi_frame(cmd(3'd5), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("f2_miso", {16'd0, mw}, 32'h0A5C);
    chk("f2_done", done_cnt - d0, 1);
    chk("f2_last", {29'd0, last_chnnl}, 32'd5);

    // Extreme channels 7 and 0.
    tbl_write(3'd7, 12'hFFF);
    tbl_write(3'd0, 12'h123);
    spi_frame(cmd(3'd7), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("c7_prev_miso", {16'd0, mw}, 32'h0A5C);
    spi_frame(cmd(3'd0), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("c7_miso", {16'd0, mw}, 32'h0FFF);
    chk("c0_last", {29'd0, last_chnnl}, 32'd0);
    spi_frame(cmd(3'd5), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("c0_miso", {16'd0, mw}, 32'h0123);
    chk("c5_last", {29'd0, last_chnnl}, 32'd5);

    // Aborted frame after 9 rises.
    d0 = done_cnt;
    spi_frame(cmd(3'd3), 9, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("abort_done", done_cnt - d0, 0);
    chk("abort_last", {29'd0, last_chnnl}, 32'd5);
    spi_frame(cmd(3'd5), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("after_abort_miso", {16'd0, mw}, 32'h0A5C);

    // Mid-frame write must not disturb the data already loaded.
    spi_frame(cmd(3'd5), 16, 1'b1, 4, 3'd5, 12'h111, mw);
    chk("midwr_miso", {16'd0, mw}, 32'h0A5C);
    spi_frame(cmd(3'd2), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("midwr_next_miso", {16'd0, mw}, 32'h0111);
    chk("midwr_last", {29'd0, last_chnnl}, 32'd2);

    // Write coinciding with the SS_n fall detect is forwarded.
    spi_frame(cmd(3'd2), 16, 1'b1, -1, 3'd2, 12'h3B6, mw);
    chk("bypass_miso", {16'd0, mw}, 32'h03B6);

    // 20 rises in one frame: extra rises ignored.
    d0 = done_cnt;
    spi_frame(cmd(3'd2), 20, 1'b0, -2, 3'd0, 12'h0, mw);
    chk("over_miso", {16'd0, mw}, 32'h03B6);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("over_miso_ss_high", {31'd0, MISO}, 32'd1);
    chk("over_done", done_cnt - d0, 1);
    chk("over_last", {29'd0, last_chnnl}, 32'd2);

    // Reset mid-frame, released with SS_n still low.
    d0 = done_cnt;
    spi_frame(cmd(3'd6), 8, 1'b0, -2, 3'd0, 12'h0, mw);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_miso", {31'd0, MISO}, 32'd1);
    chk("midrst_last", {29'd0, last_chnnl}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_done", done_cnt - d0, 0);
    chk("midrst_last_after", {29'd0, last_chnnl}, 32'd0);
    spi_frame(cmd(3'd4), 16, 1'b1, -2, 3'd0, 12'h0, mw);
    chk("postrst_miso", {16'd0, mw}, 32'h0000);
    chk("postrst_done", done_cnt - d0, 1);
    chk("postrst_last", {29'd0, last_chnnl}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
